// File: rtl/pdp8_mem_arb.sv
// pdp8_mem_arb: serialises the CPU memory port and the RF08 data-break port
// onto one external synchronous RAM with a fixed access time of MEM_WAIT
// cycles. DMA wins simultaneous requests unless the previous grant was also
// DMA, so the CPU always gets every other slot under contention.
//
// Handshake (both requester ports): the requester raises read_req and/or
// write_req as a level and keeps it high until done rises. ma/out are
// sampled only on the grant edge. done stays high for as long as the
// request is held. Dropping the request drops done on the next edge and
// returns the arbiter to IDLE (4-phase). read_req+write_req together
// is a write.
//
// dbg_state_o: 0 = IDLE, 1 = ACCESS, 2 = ACK.
module pdp8_mem_arb #(
    parameter int AW       = 15,
    parameter int DW       = 12,
    parameter int MEM_WAIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_read_req,
    input  logic          cpu_write_req,
    input  logic [AW-1:0] cpu_ma,
    input  logic [DW-1:0] cpu_out,
    output logic [DW-1:0] cpu_in,
    output logic          cpu_done,
    input  logic          dma_read_req,
    input  logic          dma_write_req,
    input  logic [AW-1:0] dma_ma,
    input  logic [DW-1:0] dma_out,
    output logic [DW-1:0] dma_in,
    output logic          dma_done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [1:0]    dbg_state_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    localparam logic       OWN_CPU  = 1'b0;
    localparam logic       OWN_DMA  = 1'b1;

    // MEM_WAIT is limited to 1..15, so four bits hold the countdown.
    localparam logic [3:0] CNT_INIT = 4'(MEM_WAIT - 1);

    logic [1:0]    state_q,     state_d;
    logic          owner_q,     owner_d;
    logic          last_dma_q,  last_dma_d;
    logic [3:0]    cnt_q,       cnt_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_ce_q,    mem_ce_d;
    logic          mem_we_q,    mem_we_d;
    logic [DW-1:0] cpu_in_q,    cpu_in_d;
    logic [DW-1:0] dma_in_q,    dma_in_d;
    logic          cpu_done_q,  cpu_done_d;
    logic          dma_done_q,  dma_done_d;

    logic cpu_rq;
    logic dma_rq;
    logic grant_dma;
    logic owner_rq;

    assign cpu_rq    = cpu_read_req | cpu_write_req;
    assign dma_rq    = dma_read_req | dma_write_req;
    // DMA takes the slot unless the CPU is also waiting and DMA had the last one.
    assign grant_dma = dma_rq & (~cpu_rq | ~last_dma_q);
    assign owner_rq  = (owner_q == OWN_DMA) ? dma_rq : cpu_rq;

    // Next-state logic: arbitration in IDLE, countdown in ACCESS, handshake in ACK.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_dma_d  = last_dma_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_ce_d    = mem_ce_q;
        mem_we_d    = mem_we_q;
        cpu_in_d    = cpu_in_q;
        dma_in_d    = dma_in_q;
        cpu_done_d  = cpu_done_q;
        dma_done_d  = dma_done_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_rq || dma_rq) begin
                    owner_d     = grant_dma ? OWN_DMA : OWN_CPU;
                    last_dma_d  = grant_dma;
                    mem_addr_d  = grant_dma ? dma_ma : cpu_ma;
                    mem_wdata_d = grant_dma ? dma_out : cpu_out;
                    mem_we_d    = grant_dma ? dma_write_req : cpu_write_req;
                    mem_ce_d    = 1'b1;
                    cnt_d       = CNT_INIT;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_ce_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner_q == OWN_DMA) begin
                        dma_done_d = 1'b1;
                        if (!mem_we_q) dma_in_d = mem_rdata;
                    end else begin
                        cpu_done_d = 1'b1;
                        if (!mem_we_q) cpu_in_d = mem_rdata;
                    end
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!owner_rq) begin
                    cpu_done_d = 1'b0;
                    dma_done_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any access in flight without a done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_CPU;
            last_dma_q  <= 1'b0;
            cnt_q       <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_in_q    <= '0;
            dma_in_q    <= '0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_dma_q  <= last_dma_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            cpu_in_q    <= cpu_in_d;
            dma_in_q    <= dma_in_d;
            cpu_done_q  <= cpu_done_d;
            dma_done_q  <= dma_done_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_ce      = mem_ce_q;
    assign mem_we      = mem_we_q;
    assign cpu_in      = cpu_in_q;
    assign cpu_done    = cpu_done_q;
    assign dma_in      = dma_in_q;
    assign dma_done    = dma_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pdp8_mem_arb.sv
// Bench for pdp8_mem_arb: external RAM model, two requester drivers,
// a monitor that scores every grant and every done against a reference
// memory and the arbitration rules, directed scenarios, then random traffic.
`timescale 1ns/1ps
module tb_pdp8_mem_arb;

    localparam int AW = 15;
    localparam int DW = 12;
    localparam int MW = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic P_CPU = 1'b0;
    localparam logic P_DMA = 1'b1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          cpu_read_req = 1'b0, cpu_write_req = 1'b0;
    logic [AW-1:0] cpu_ma = '0;
    logic [DW-1:0] cpu_out = '0;
    logic [DW-1:0] cpu_in;
    logic          cpu_done;
    logic          dma_read_req = 1'b0, dma_write_req = 1'b0;
    logic [AW-1:0] dma_ma = '0;
    logic [DW-1:0] dma_out = '0;
    logic [DW-1:0] dma_in;
    logic          dma_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ce, mem_we;
    logic [1:0]    dbg_state;

    pdp8_mem_arb #(.AW(AW), .DW(DW), .MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .cpu_read_req(cpu_read_req), .cpu_write_req(cpu_write_req),
        .cpu_ma(cpu_ma), .cpu_out(cpu_out), .cpu_in(cpu_in), .cpu_done(cpu_done),
        .dma_read_req(dma_read_req), .dma_write_req(dma_write_req),
        .dma_ma(dma_ma), .dma_out(dma_out), .dma_in(dma_in), .dma_done(dma_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .dbg_state_o(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- external RAM model ----------------
    // Read data is only valid in the last cycle of a MW-cycle enable burst;
    // otherwise the bus carries noise. Writes commit at the same point.
    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int ce_age = 0;
    always @(posedge clk) begin
        #1;
        if (mem_ce === 1'b1) ce_age++;
        else ce_age = 0;
        if (mem_ce === 1'b1 && ce_age == MW) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            mem_rdata = ram[mem_addr];
        end else begin
            mem_rdata = DW'($urandom);
        end
    end

    // ---------------- scoreboard state ----------------
    // Entry layout: {we, addr, data}
    logic [AW+DW:0] cpu_exp_q[$];
    logic [AW+DW:0] dma_exp_q[$];
    logic           exp_owner_q[$];
    logic           obs_q[$];
    logic           last_dma_m = 1'b0;
    logic [DW-1:0]  cpu_last_rd = '0, dma_last_rd = '0;

    logic ce_prev = 1'b0, cpu_done_prev = 1'b0, dma_done_prev = 1'b0;
    logic cpu_rq_prev = 1'b0, dma_rq_prev = 1'b0;
    int   ce_len = 0, grant_cyc = 0, ce_bursts = 0, dma_fall_cyc = 0;
    int   cpu_hi = 0, dma_hi = 0, cpu_done_len = 0, dma_done_len = 0;
    logic [AW-1:0] last_ce_addr = '0;

    task automatic handle_done(input logic port);
        logic [AW+DW:0] e;
        logic           o;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
        logic [DW-1:0]  act_in;
        obs_q.push_back(port);
        if (exp_owner_q.size() == 0) begin
            check("done_without_grant", 32'(port), 32'hFFFF);
        end else begin
            o = exp_owner_q.pop_front();
            check("done_owner", 32'(port), 32'(o));
        end
        if (port == P_DMA && dma_exp_q.size() == 0) begin
            check("dma_done_unexpected", 1, 0);
        end else if (port == P_CPU && cpu_exp_q.size() == 0) begin
            check("cpu_done_unexpected", 1, 0);
        end else begin
            e = (port == P_DMA) ? dma_exp_q.pop_front() : cpu_exp_q.pop_front();
            a = e[AW+DW-1:DW];
            d = e[DW-1:0];
            act_in = (port == P_DMA) ? dma_in : cpu_in;
            check("done_latency", 32'(cyc - grant_cyc), 32'(MW));
            if (e[AW+DW]) begin
                ref_mem[a] = d;
                check("in_held_on_write", 32'(act_in),
                      32'((port == P_DMA) ? dma_last_rd : cpu_last_rd));
            end else begin
                check("read_data", 32'(act_in), 32'(ref_mem[a]));
                if (port == P_DMA) dma_last_rd = ref_mem[a];
                else cpu_last_rd = ref_mem[a];
            end
        end
    endtask

    // ---------------- monitor ----------------
    // Scores grants on the rising edge of mem_ce and completions on the
    // rising edge of each done; arbitration uses the requests the DUT saw.
    always @(negedge clk) begin
        logic win;
        logic [AW+DW:0] f;
        if (reset) begin
            cpu_exp_q.delete();
            dma_exp_q.delete();
            exp_owner_q.delete();
            last_dma_m  = 1'b0;
            cpu_last_rd = '0;
            dma_last_rd = '0;
            ce_prev = 1'b0; cpu_done_prev = 1'b0; dma_done_prev = 1'b0;
            cpu_rq_prev = 1'b0; dma_rq_prev = 1'b0;
            cpu_hi = 0; dma_hi = 0;
        end else begin
            if (mem_ce && !ce_prev) begin
                ce_len = 1;
                grant_cyc = cyc;
                ce_bursts++;
                last_ce_addr = mem_addr;
                if (!cpu_rq_prev && !dma_rq_prev) begin
                    check("spurious_grant", 1, 0);
                end else begin
                    win = dma_rq_prev && (!cpu_rq_prev || !last_dma_m);
                    last_dma_m = win;
                    exp_owner_q.push_back(win);
                    if ((win && dma_exp_q.size() == 0) || (!win && cpu_exp_q.size() == 0)) begin
                        check("grant_no_request", 1, 0);
                    end else begin
                        f = win ? dma_exp_q[0] : cpu_exp_q[0];
                        check("grant_addr", 32'(mem_addr), 32'(f[AW+DW-1:DW]));
                        check("grant_we", 32'(mem_we), 32'(f[AW+DW]));
                        if (f[AW+DW]) check("grant_wdata", 32'(mem_wdata), 32'(f[DW-1:0]));
                    end
                end
            end else if (mem_ce) begin
                ce_len++;
            end
            if (!mem_ce && ce_prev) check("ce_burst_len", 32'(ce_len), 32'(MW));

            if (cpu_done || dma_done) check("done_exclusive", 32'(cpu_done & dma_done), 0);
            if (cpu_done && !cpu_done_prev) handle_done(P_CPU);
            if (dma_done && !dma_done_prev) handle_done(P_DMA);

            if (cpu_done) cpu_hi++;
            else if (cpu_done_prev) begin cpu_done_len = cpu_hi; cpu_hi = 0; end
            if (dma_done) dma_hi++;
            else if (dma_done_prev) begin dma_done_len = dma_hi; dma_hi = 0; dma_fall_cyc = cyc; end

            ce_prev       = mem_ce;
            cpu_done_prev = cpu_done;
            dma_done_prev = dma_done;
            cpu_rq_prev   = cpu_read_req | cpu_write_req;
            dma_rq_prev   = dma_read_req | dma_write_req;
        end
    end

    // ---------------- driver ----------------
    // One full 4-phase transaction on a port; done is kept visible for
    // 'hold' cycles before the request drops. Called 1ns after a posedge.
    task automatic access(input logic port, input logic we, input logic both,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
        int  n;
        logic dn;
        if (port == P_DMA) begin
            dma_exp_q.push_back({we, a, d});
            dma_ma = a; dma_out = d; dma_write_req = we; dma_read_req = !we || both;
        end else begin
            cpu_exp_q.push_back({we, a, d});
            cpu_ma = a; cpu_out = d; cpu_write_req = we; cpu_read_req = !we || both;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            dn = (port == P_DMA) ? dma_done : cpu_done;
        end while (!dn && n < 200);
        if (!dn) check(port ? "dma_timeout" : "cpu_timeout", 0, 1);
        else repeat (hold - 1) begin @(posedge clk); #1; end
        if (port == P_DMA) begin dma_read_req = 1'b0; dma_write_req = 1'b0; end
        else begin cpu_read_req = 1'b0; cpu_write_req = 1'b0; end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            dn = (port == P_DMA) ? dma_done : cpu_done;
        end while (dn && n < 10);
        if (dn) check(port ? "dma_done_stuck" : "cpu_done_stuck", 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_obs, base_bursts;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_ce", 32'(mem_ce), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_cpu_done", 32'(cpu_done), 0);
        check("rst_dma_done", 32'(dma_done), 0);
        check("rst_cpu_in", 32'(cpu_in), 0);
        check("rst_dma_in", 32'(dma_in), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset during a DMA write in ACCESS
        dma_ma = 15'o77777; dma_out = 12'o1111; dma_write_req = 1'b1;
        @(posedge clk); #3;
        check("t1_ce_started", 32'(mem_ce), 1);
        check("t1_we_started", 32'(mem_we), 1);
        reset = 1'b1;
        #1;
        check("t1_ce_async", 32'(mem_ce), 0);
        check("t1_we_async", 32'(mem_we), 0);
        check("t1_dma_done", 32'(dma_done), 0);
        check("t1_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        dma_write_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // CPU write then read back
        access(P_CPU, 1'b1, 1'b0, 15'o01234, 12'o7654, 1);
        access(P_CPU, 1'b0, 1'b0, 15'o01234, 12'o0000, 1);
        check("t2_cpu_in", 32'(cpu_in), 32'(12'o7654));

        // Simultaneous reads, DMA first, CPU right after DMA returns to IDLE
        ram[15'o00100] = 12'o0101; ref_mem[15'o00100] = 12'o0101;
        ram[15'o00200] = 12'o0202; ref_mem[15'o00200] = 12'o0202;
        base_obs = obs_q.size();
        fork
            access(P_DMA, 1'b0, 1'b0, 15'o00100, 12'o0, 1);
            access(P_CPU, 1'b0, 1'b0, 15'o00200, 12'o0, 1);
        join
        @(negedge clk); #1;
        check("t3_count", 32'(obs_q.size() - base_obs), 2);
        check("t3_first_dma", 32'(obs_q[base_obs]), 32'(P_DMA));
        check("t3_then_cpu", 32'(obs_q[base_obs + 1]), 32'(P_CPU));
        check("t3_cpu_gap", 32'(grant_cyc - dma_fall_cyc), 1);
        check("t3_dma_in", 32'(dma_in), 32'(12'o0101));
        check("t3_cpu_in", 32'(cpu_in), 32'(12'o0202));
        @(posedge clk); #1;

        // Back-to-back DMA against a waiting CPU: DMA, CPU, DMA
        base_obs = obs_q.size();
        fork
            begin
                access(P_DMA, 1'b1, 1'b0, 15'o00300, 12'o1234, 1);
                access(P_DMA, 1'b0, 1'b0, 15'o00300, 12'o0, 1);
            end
            access(P_CPU, 1'b0, 1'b0, 15'o00100, 12'o0, 1);
        join
        @(negedge clk); #1;
        check("t4_count", 32'(obs_q.size() - base_obs), 3);
        check("t4_g0_dma", 32'(obs_q[base_obs]), 32'(P_DMA));
        check("t4_g1_cpu", 32'(obs_q[base_obs + 1]), 32'(P_CPU));
        check("t4_g2_dma", 32'(obs_q[base_obs + 2]), 32'(P_DMA));
        check("t4_dma_in", 32'(dma_in), 32'(12'o1234));
        @(posedge clk); #1;

        // Request held 5 cycles past done: done high 5 cycles, one burst only
        base_bursts = ce_bursts;
        access(P_CPU, 1'b0, 1'b0, 15'o00200, 12'o0, 5);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check("t5_done_len", 32'(cpu_done_len), 5);
        check("t5_one_burst", 32'(ce_bursts - base_bursts), 1);
        @(posedge clk); #1;

        // Single-word data-break read from a preloaded location
        ram[15'o01000] = 12'o4321; ref_mem[15'o01000] = 12'o4321;
        base_bursts = ce_bursts;
        access(P_DMA, 1'b0, 1'b0, 15'o01000, 12'o0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("t6_one_burst", 32'(ce_bursts - base_bursts), 1);
        check("t6_addr", 32'(last_ce_addr), 32'(15'o01000));
        check("t6_dma_in", 32'(dma_in), 32'(12'o4321));
        check("t6_done_low", 32'(dma_done), 0);
        @(posedge clk); #1;

        // Random concurrent traffic on both ports
        fork
            for (int i = 0; i < 40; i++) begin
                access(P_CPU, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       AW'($urandom_range(0, 31)), DW'($urandom), $urandom_range(1, 4));
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            for (int j = 0; j < 40; j++) begin
                access(P_DMA, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       AW'($urandom_range(0, 31)), DW'($urandom), $urandom_range(1, 4));
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
        join

        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        check("end_cpu_q_empty", 32'(cpu_exp_q.size()), 0);
        check("end_dma_q_empty", 32'(dma_exp_q.size()), 0);
        check("end_owner_q_empty", 32'(exp_owner_q.size()), 0);
        check("end_idle", 32'(dbg_state), 32'(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
